// File: rtl/uart_pkg.sv
// Shared UART definitions: frame states, default widths and the idle line level.
// Used by both the TX controller and the baud counter.
package uart_pkg;

   localparam int   UART_DATA_WIDTH = 8;
   localparam int   UART_DIV_W      = 16;
   localparam logic UART_IDLE_LEVEL = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } uart_state_t;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Producer-side handshake and serial outputs of the UART TX frame controller.
// The producer (TX holding register/FIFO) owns the master modport.
interface uart_tx_ctrl_if
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = UART_DATA_WIDTH,
   parameter int DIV_W      = UART_DIV_W
);

   logic                  data_valid;
   logic [DATA_WIDTH-1:0] parallel_data;
   logic                  parity_en;
   logic [DIV_W-1:0]      baud_div;
   logic                  tx_out;
   logic                  busy;
   logic                  data_ack;

   modport master (
      output data_valid, parallel_data, parity_en, baud_div,
      input  tx_out, busy, data_ack
   );

   modport slave (
      input  data_valid, parallel_data, parity_en, baud_div,
      output tx_out, busy, data_ack
   );

endinterface

// File: rtl/uart_baud_counter.sv
// Bit-period counter: bit_end marks the last UCLK cycle of each bit.
// Restart forces a fresh bit period; shared with the RX path.
module uart_baud_counter
   import uart_pkg::*;
#(
   parameter int DIV_W = UART_DIV_W
) (
   input  logic             UCLK,
   input  logic             reset,
   input  logic             enable,
   input  logic             restart,
   input  logic [DIV_W-1:0] div,
   output logic             bit_end
);

   logic [DIV_W-1:0] r_cnt;

   // div is never 0 here; the owner substitutes 1 when latching
   assign bit_end = enable && (r_cnt == (div - DIV_W'(1)));

   always_ff @(posedge UCLK) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (restart || !enable || bit_end) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + DIV_W'(1);
      end
   end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART TX frame controller: start bit, LSB-first data, optional odd parity, one stop bit.
// All outputs are registered from the next-state values so the line has no input-to-output path.
module uart_tx_ctrl
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = UART_DATA_WIDTH,
   parameter int DIV_W      = UART_DIV_W
) (
   input  logic           UCLK,
   input  logic           reset,
   uart_tx_ctrl_if.slave  bus
);

   localparam int                CNT_W    = $clog2(DATA_WIDTH + 1);
   localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   uart_state_t           r_state,     w_state_next;
   logic [DATA_WIDTH-1:0] r_shift,     w_shift_next;
   logic [CNT_W-1:0]      r_bit_cnt,   w_bit_cnt_next;
   logic                  r_parity,    w_parity_next;
   logic                  r_parity_en, w_parity_en_next;
   logic [DIV_W-1:0]      r_div,       w_div_next;
   logic                  r_tx,        w_tx_next;
   logic                  r_busy,      w_busy_next;
   logic                  r_ack,       w_ack_next;
   logic                  w_bit_end;
   logic                  w_accept;

   uart_baud_counter #(
      .DIV_W (DIV_W)
   ) u_baud (
      .UCLK    (UCLK),
      .reset   (reset),
      .enable  (r_state != ST_IDLE),
      .restart (w_accept),
      .div     (r_div),
      .bit_end (w_bit_end)
   );

   always_comb begin
      w_state_next     = r_state;
      w_shift_next     = r_shift;
      w_bit_cnt_next   = r_bit_cnt;
      w_parity_next    = r_parity;
      w_parity_en_next = r_parity_en;
      w_div_next       = r_div;
      w_accept         = 1'b0;

      unique case (r_state)
         ST_IDLE: begin
            w_accept = bus.data_valid;
         end
         ST_START: begin
            if (w_bit_end) w_state_next = ST_DATA;
         end
         ST_DATA: begin
            if (w_bit_end) begin
               w_shift_next   = r_shift >> 1;
               w_bit_cnt_next = r_bit_cnt + CNT_W'(1);
               if (r_bit_cnt == LAST_BIT) begin
                  w_state_next = r_parity_en ? ST_PARITY : ST_STOP;
               end
            end
         end
         ST_PARITY: begin
            if (w_bit_end) w_state_next = ST_STOP;
         end
         ST_STOP: begin
            // a word waiting at the end of the stop bit chains with no idle gap
            if (w_bit_end) begin
               if (bus.data_valid) w_accept     = 1'b1;
               else                w_state_next = ST_IDLE;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase

      if (w_accept) begin
         w_state_next     = ST_START;
         w_shift_next     = bus.parallel_data;
         w_parity_next    = ~^bus.parallel_data;
         w_parity_en_next = bus.parity_en;
         w_div_next       = (bus.baud_div == '0) ? DIV_W'(1) : bus.baud_div;
         w_bit_cnt_next   = '0;
      end

      unique case (w_state_next)
         ST_START:  w_tx_next = 1'b0;
         ST_DATA:   w_tx_next = w_shift_next[0];
         ST_PARITY: w_tx_next = w_parity_next;
         default:   w_tx_next = UART_IDLE_LEVEL;
      endcase

      w_busy_next = (w_state_next != ST_IDLE);
      w_ack_next  = w_accept;
   end

   always_ff @(posedge UCLK) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_shift     <= '0;
         r_bit_cnt   <= '0;
         r_parity    <= 1'b0;
         r_parity_en <= 1'b0;
         r_div       <= DIV_W'(1);
         r_tx        <= UART_IDLE_LEVEL;
         r_busy      <= 1'b0;
         r_ack       <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_shift     <= w_shift_next;
         r_bit_cnt   <= w_bit_cnt_next;
         r_parity    <= w_parity_next;
         r_parity_en <= w_parity_en_next;
         r_div       <= w_div_next;
         r_tx        <= w_tx_next;
         r_busy      <= w_busy_next;
         r_ack       <= w_ack_next;
      end
   end

   assign bus.tx_out   = r_tx;
   assign bus.busy     = r_busy;
   assign bus.data_ack = r_ack;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: frames queued at drive time are checked cycle by cycle
// against the serial line once the matching data_ack appears.
module tb_uart_tx_ctrl;
   import uart_pkg::*;

   typedef struct {
      logic [7:0]  data;
      logic        pen;
      logic [15:0] div;
   } frame_t;

   logic UCLK  = 1'b0;
   logic reset = 1'b0;
   always #5 UCLK = ~UCLK;

   uart_tx_ctrl_if #(.DATA_WIDTH(8), .DIV_W(16)) bus ();

   uart_tx_ctrl #(.DATA_WIDTH(8), .DIV_W(16)) dut (
      .UCLK  (UCLK),
      .reset (reset),
      .bus   (bus.slave)
   );

   frame_t exp_q[$];
   int     ack_cyc[$];
   int     n_checks = 0;
   int     n_fail   = 0;
   int     cyc      = 0;
   logic   rst_seen = 1'b0;

   bit     mon_active = 1'b0;
   bit     mon_ended  = 1'b0;
   int     mon_pos, mon_div, mon_len;
   logic   mon_bits [0:10];
   frame_t mon_f;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // reset as the DUT sampled it at the most recent rising edge
   initial forever begin
      @(posedge UCLK);
      rst_seen = reset;
      cyc++;
   end

   // line monitor / scoreboard consumer
   initial forever begin
      @(negedge UCLK);
      if (!rst_seen) begin
         mon_active = 1'b0;
         mon_ended  = 1'b0;
         check_eq("reset_outputs", {bus.tx_out, bus.busy, bus.data_ack}, 3'b100);
      end else if (bus.data_ack) begin
         ack_cyc.push_back(cyc);
         if (mon_active && !mon_ended) check_eq("early_ack_pos", mon_pos, mon_len);
         if (exp_q.size() == 0) begin
            check_eq("unexpected_ack_qsize", exp_q.size(), 1);
            mon_active = 1'b0;
            mon_ended  = 1'b0;
         end else begin
            int ones;
            int idx;
            mon_f = exp_q.pop_front();
            mon_div = (mon_f.div == 16'd0) ? 1 : int'(mon_f.div);
            mon_bits[0] = 1'b0;
            ones = 0;
            for (int i = 0; i < 8; i++) begin
               mon_bits[1+i] = mon_f.data[i];
               if (mon_f.data[i]) ones++;
            end
            idx = 9;
            if (mon_f.pen) begin
               mon_bits[idx] = ((ones % 2) == 0) ? 1'b1 : 1'b0;
               idx++;
            end
            mon_bits[idx] = 1'b1;
            mon_len    = (idx + 1) * mon_div;
            mon_pos    = 0;
            mon_active = 1'b1;
            mon_ended  = 1'b0;
         end
      end else if (mon_ended) begin
         check_eq("frame_end_tx_busy", {bus.tx_out, bus.busy}, 2'b10);
         $display("frame data=%02h pen=%0d div=%0d len=%0d done at cycle %0d",
                  mon_f.data, mon_f.pen, mon_div, mon_len, cyc);
         mon_active = 1'b0;
         mon_ended  = 1'b0;
      end else if (!mon_active) begin
         check_eq("idle_outputs", {bus.tx_out, bus.busy, bus.data_ack}, 3'b100);
      end

      if (mon_active && !mon_ended) begin
         check_eq("tx_bit", bus.tx_out, mon_bits[mon_pos / mon_div]);
         check_eq("busy_in_frame", bus.busy, 1'b1);
         mon_pos++;
         if (mon_pos == mon_len) mon_ended = 1'b1;
      end
   end

   task automatic drive(input logic [7:0] d, input logic pen, input logic [15:0] div);
      frame_t f;
      f.data = d;
      f.pen  = pen;
      f.div  = div;
      exp_q.push_back(f);
      bus.data_valid    = 1'b1;
      bus.parallel_data = d;
      bus.parity_en     = pen;
      bus.baud_div      = div;
   endtask

   task automatic wait_ack(input string tag);
      int n = 0;
      do begin
         @(negedge UCLK);
         n++;
      end while (!bus.data_ack && n < 400);
      check_eq({tag, "_ack_seen"}, bus.data_ack, 1'b1);
      @(posedge UCLK);
      #1;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while ((exp_q.size() != 0 || mon_active) && n < 3000) begin
         @(negedge UCLK);
         n++;
      end
      check_eq({tag, "_done"}, (exp_q.size() == 0 && !mon_active) ? 1 : 0, 1);
      repeat (2) @(posedge UCLK);
      #1;
   endtask

   task automatic send(input string tag, input logic [7:0] d, input logic pen, input logic [15:0] div);
      drive(d, pen, div);
      wait_ack(tag);
      bus.data_valid = 1'b0;
      wait_idle(tag);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.data_valid    = 1'b0;
      bus.parallel_data = 8'h00;
      bus.parity_en     = 1'b0;
      bus.baud_div      = 16'd0;
      reset             = 1'b0;
      repeat (3) @(posedge UCLK);
      #1 reset = 1'b1;
      repeat (3) @(posedge UCLK);
      #1;

      send("a5_par_div4", 8'hA5, 1'b1, 16'd4);
      check_eq("a5_single_ack", ack_cyc.size(), 1);
      send("00_nopar_div0", 8'h00, 1'b0, 16'd0);

      // back-to-back with data_valid held high
      drive(8'hFF, 1'b1, 16'd2);
      wait_ack("b2b_first");
      drive(8'h01, 1'b1, 16'd2);
      wait_ack("b2b_second");
      bus.data_valid = 1'b0;
      wait_idle("b2b");
      check_eq("b2b_ack_gap", ack_cyc[ack_cyc.size()-1] - ack_cyc[ack_cyc.size()-2], 22);

      // inputs wiggled mid-frame must not disturb the latched frame
      drive(8'h5A, 1'b0, 16'd3);
      wait_ack("midchg");
      bus.data_valid = 1'b0;
      repeat (6) @(posedge UCLK);
      #1;
      for (int i = 0; i < 8; i++) begin
         bus.parallel_data = 8'($urandom);
         bus.parity_en     = ~bus.parity_en;
         bus.baud_div      = 16'($urandom_range(0, 7));
         @(posedge UCLK);
         #1;
      end
      wait_idle("midchg");

      // reset during DATA bit 3 abandons the frame
      drive(8'h96, 1'b1, 16'd4);
      wait_ack("rst_frame");
      bus.data_valid = 1'b0;
      repeat (16) @(posedge UCLK);
      #1 reset = 1'b0;
      @(posedge UCLK);
      #1 reset = 1'b1;
      @(negedge UCLK);
      check_eq("rst_tx_out", bus.tx_out, 1'b1);
      check_eq("rst_busy", bus.busy, 1'b0);
      check_eq("rst_data_ack", bus.data_ack, 1'b0);
      @(posedge UCLK);
      #1;
      check_eq("rst_queue_empty", exp_q.size(), 0);
      send("3c_after_rst", 8'h3C, 1'b1, 16'd4);

      for (int i = 0; i < 4; i++) begin
         send("rand", 8'($urandom), 1'($urandom), 16'($urandom_range(0, 3)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
